// File: rtl/clk_scan_display.sv
// Purpose : 4-digit multiplexed 7-segment driver for the stopwatch (mm.ss); optional edit-digit/separator blink under CLK_SCAN_BLINK_EN.
// Latency : outputs registered, 1 cycle from slot state; input digits are sampled into a shadow once per frame.
// Backpres: none, free-running scan with no handshake; inputs are sampled, never stalled.
module clk_scan_display #(
  parameter int SCAN_DIV  = 125000,
  parameter int BLINK_DIV = 62500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min_cnt2,
  input  logic [3:0] min_cnt1,
  input  logic [2:0] sec_cnt2,
  input  logic [3:0] sec_cnt1,
  input  logic [1:0] current_state,
  input  logic [1:0] edit_digit,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [SCAN_W-1:0] scan_cnt;
  logic              tick;
  logic [1:0]        dsel;
  logic [3:0][3:0]   shadow;
  logic [3:0]        cur_digit;
  logic [6:0]        seg_dec;
  logic              slot_hide;
  logic              dp_mute;

  // Last cycle of each slot: used as the one-cycle blanking slot
  always_comb tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  // Slot prescaler, 0..SCAN_DIV-1
  always_ff @(posedge clk) begin
    if (reset)     scan_cnt <= '0;
    else if (tick) scan_cnt <= '0;
    else           scan_cnt <= scan_cnt + 1'b1;
  end

  // Slot pointer advances at the end of every slot
  always_ff @(posedge clk) begin
    if (reset)     dsel <= 2'd0;
    else if (tick) dsel <= dsel + 2'd1;
  end

  // Snapshot all digits at frame end so one frame never mixes old and new time
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (tick && (dsel == 2'd3)) begin
      shadow[0] <= sec_cnt1;
      shadow[1] <= {1'b0, sec_cnt2};
      shadow[2] <= min_cnt1;
      shadow[3] <= min_cnt2;
    end
  end

  // BCD to active-low segments {g,f,e,d,c,b,a}; non-BCD values show dark
  always_comb begin
    cur_digit = shadow[dsel];
    case (cur_digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

`ifdef CLK_SCAN_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [1:0]         prev_state;
  logic [1:0]         prev_edit;
  logic               mode_chg;

  // Previous-cycle copy of mode inputs; tracks through reset so release sees no change
  always_ff @(posedge clk) begin
    prev_state <= current_state;
    prev_edit  <= edit_digit;
  end

  // Any mode or edit-digit change restarts the blink so the new target starts visible
  always_comb mode_chg = (current_state != prev_state) || (edit_digit != prev_edit);

  // Blink half-period counter and phase
  always_ff @(posedge clk) begin
    if (reset || mode_chg) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Blink the edited digit in down_wait, the separator in either run state
  always_comb begin
    slot_hide = blink_phase && (current_state == 2'b10) && (edit_digit == dsel);
    dp_mute   = blink_phase && current_state[0];
  end
`else
  logic unused_cfg;

  // Mode inputs and blink period only matter when blinking is built in
  always_comb begin
    unused_cfg = ^{current_state, edit_digit, 1'(BLINK_DIV)};
    slot_hide  = 1'b0;
    dp_mute    = 1'b0;
  end
`endif

  // Registered display outputs: blank on tick, otherwise drive slot dsel
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= slot_hide ? 4'b1111 : ~(4'b0001 << dsel);
      seg <= seg_dec;
      dp  <= ~((dsel == 2'd2) && !dp_mute);
    end
  end

endmodule

// File: tb/tb_clk_scan_display.sv
// Purpose : directed self-checking bench for clk_scan_display at SCAN_DIV=4, BLINK_DIV=16.
// Latency : outputs sampled on the falling edge after the rising edge under test.
// Backpres: none; blink expectations switch with CLK_SCAN_BLINK_EN.
module tb_clk_scan_display;

  logic       clk;
  logic       reset;
  logic [3:0] min_cnt2;
  logic [3:0] min_cnt1;
  logic [2:0] sec_cnt2;
  logic [3:0] sec_cnt1;
  logic [1:0] current_state;
  logic [1:0] edit_digit;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  clk_scan_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .min_cnt2      (min_cnt2),
    .min_cnt1      (min_cnt1),
    .sec_cnt2      (sec_cnt2),
    .sec_cnt1      (sec_cnt1),
    .current_state (current_state),
    .edit_digit    (edit_digit),
    .an            (an),
    .seg           (seg),
    .dp            (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Step n rising edges; returns on the following falling edge
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    min_cnt2 = 4'd1; min_cnt1 = 4'd2; sec_cnt2 = 3'd3; sec_cnt1 = 4'd4;
    current_state = 2'b00; edit_digit = 2'd0;

    // Reset state
    adv(3);
    chk("rst_an", 16'(an), 16'h000f);
    chk("rst_seg", 16'(seg), 16'h007f);
    chk("rst_dp", 16'(dp), 16'h0001);

    // Release; edges counted E1.. from here
    reset = 1'b0;
    adv(1);   // E1
    chk("f0_s0_an", 16'(an), 16'(4'b1110));
    chk("f0_s0_seg", 16'(seg), 16'(7'b1000000));
    chk("f0_s0_dp", 16'(dp), 16'h0001);
    adv(3);   // E4
    chk("f0_blank_an", 16'(an), 16'(4'b1111));
    adv(5);   // E9
    chk("f0_s2_an", 16'(an), 16'(4'b1011));
    chk("f0_s2_dp", 16'(dp), 16'h0000);
    chk("f0_s2_seg", 16'(seg), 16'(7'b1000000));
    adv(8);   // E17
    chk("f1_s0_an", 16'(an), 16'(4'b1110));
    chk("f1_s0_seg", 16'(seg), 16'(7'b0011001));
    adv(4);   // E21
    chk("f1_s1_an", 16'(an), 16'(4'b1101));
    chk("f1_s1_seg", 16'(seg), 16'(7'b0110000));
    adv(4);   // E25
    chk("f1_s2_seg", 16'(seg), 16'(7'b0100100));
    chk("f1_s2_dp", 16'(dp), 16'h0000);
    adv(4);   // E29
    chk("f1_s3_an", 16'(an), 16'(4'b0111));
    chk("f1_s3_seg", 16'(seg), 16'(7'b1111001));

    // Change inputs mid-frame (dsel==1): current frame keeps old digits
    adv(8);   // E37
    min_cnt2 = 4'd9; min_cnt1 = 4'd9; sec_cnt2 = 3'd5; sec_cnt1 = 4'd9;
    adv(4);   // E41
    chk("tear_s2_seg", 16'(seg), 16'(7'b0100100));
    adv(4);   // E45
    chk("tear_s3_seg", 16'(seg), 16'(7'b1111001));
    adv(4);   // E49
    chk("new_s0_an", 16'(an), 16'(4'b1110));
    chk("new_s0_seg", 16'(seg), 16'(7'b0010000));
    adv(4);   // E53
    chk("new_s1_seg", 16'(seg), 16'(7'b0010010));
    adv(8);   // E61
    chk("new_s3_seg", 16'(seg), 16'(7'b0010000));

    // Non-BCD digit: dark segments, anode still enabled, separator on
    min_cnt1 = 4'hC;
    adv(12);  // E73
    chk("hex_s2_an", 16'(an), 16'(4'b1011));
    chk("hex_s2_seg", 16'(seg), 16'(7'b1111111));
    chk("hex_s2_dp", 16'(dp), 16'h0000);

    // One-cycle reset pulse mid-slot 2
    reset = 1'b1;
    adv(1);   // E74
    chk("midrst_an", 16'(an), 16'(4'b1111));
    chk("midrst_seg", 16'(seg), 16'(7'b1111111));
    chk("midrst_dp", 16'(dp), 16'h0001);
    reset = 1'b0;
    adv(1);
    chk("postrst_an", 16'(an), 16'(4'b1110));
    chk("postrst_seg", 16'(seg), 16'(7'b1000000));

    // down_wait editing digit 1
    reset = 1'b1;
    current_state = 2'b10; edit_digit = 2'd1;
    adv(3);
    reset = 1'b0;
    adv(5);   // E5, blink phase 0
    chk("dw_s1_lit_an", 16'(an), 16'(4'b1101));
    adv(4);   // E9
    chk("dw_s2_an", 16'(an), 16'(4'b1011));
    adv(12);  // E21, blink phase 1
`ifdef CLK_SCAN_BLINK_EN
    chk("dw_s1_blink_an", 16'(an), 16'(4'b1111));
`else
    chk("dw_s1_noblink_an", 16'(an), 16'(4'b1101));
`endif
    adv(2);   // E23, move edit to digit 2 while phase is 1
    edit_digit = 2'd2;
    adv(2);   // E25
    chk("dw_edit_chg_s2_an", 16'(an), 16'(4'b1011));

    // up_run: separator blink
    reset = 1'b1;
    current_state = 2'b01; edit_digit = 2'd0;
    adv(3);
    reset = 1'b0;
    adv(9);   // E9, phase 0
    chk("run_s2_dp_on", 16'(dp), 16'h0000);
    adv(16);  // E25, phase 1
    chk("run_s2_an", 16'(an), 16'(4'b1011));
`ifdef CLK_SCAN_BLINK_EN
    chk("run_s2_dp_blink", 16'(dp), 16'h0001);
`else
    chk("run_s2_dp_steady", 16'(dp), 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_scan_display.md
CLK_SCAN_DISPLAY -- requirements
Module: clk_scan_display

Interface
Parameters (name, default, meaning):
REQ-001 SCAN_DIV, 125000, clock cycles per digit slot (1 ms at 125 MHz); legal range 2..2^17-1.
REQ-002 BLINK_DIV, 62500000, clock cycles per blink half-period (0.5 s at 125 MHz); legal range 2..2^26-1.
Ports (name, direction, width, meaning):
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 min_cnt2  in  4  BCD tens-of-minutes digit from the stopwatch counter.
REQ-006 min_cnt1  in  4  BCD minutes digit.
REQ-007 sec_cnt2  in  3  tens-of-seconds digit, zero-extended to 4 bits internally.
REQ-008 sec_cnt1  in  4  BCD seconds digit.
REQ-009 current_state  in  2  mode: 00 up_wait, 01 up_run, 10 down_wait, 11 down_run.
REQ-010 edit_digit  in  2  digit under edit in down_wait: 0 sec_cnt1, 1 sec_cnt2, 2 min_cnt1, 3 min_cnt2.
REQ-011 an  out  4  active-low anode enables: an[0] sec_cnt1, an[1] sec_cnt2, an[2] min_cnt1, an[3] min_cnt2.
REQ-012 seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-013 dp  out  1  active-low decimal point (minute/second separator).

Function
REQ-014 Prescaler scan_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = cycle where scan_cnt==SCAN_DIV-1.
REQ-015 Slot pointer dsel (2 bits) SHALL increment on each tick edge, wrapping 3->0.
REQ-016 On each tick edge an SHALL be driven 4'b1111 (one-cycle blanking slot against ghosting).
REQ-017 On every non-tick edge an SHALL drive low only the bit indexed by dsel; seg/dp SHALL reflect slot dsel on the same edge.
REQ-018 Each slot is therefore SCAN_DIV-1 cycles lit plus 1 cycle blank; full frame = 4*SCAN_DIV cycles.
REQ-019 Shadow register SHALL capture all four input digits only on the tick edge where dsel==3; displayed values come only from the shadow (no intra-frame tearing).
REQ-020 Decode: values 0-9 SHALL produce standard patterns (0 = 7'b1000000, 4 = 7'b0011001, 8 = 7'b0000000); values 10-15 SHALL produce 7'b1111111 with the anode still enabled.
REQ-021 dp SHALL be 0 only in slot 2 (separator after min_cnt1), 1 in all other slots and blank cycles, subject to REQ-025.
REQ-022 Outputs SHALL be registered; no combinational path from any input to an/seg/dp.

Reset
REQ-023 While reset is high on a clock edge: scan_cnt=0, dsel=0, shadow=0, blink counter=0, blink phase=0, an=4'b1111, seg=7'b1111111, dp=1.
REQ-024 Reset asserted mid-frame SHALL take effect on the next edge regardless of scan state; first lit slot after release is slot 0 showing shadow 0.

Configuration
REQ-025 Macro CLK_SCAN_BLINK_EN: when defined, a blink counter 0..BLINK_DIV-1 toggles phase on wrap; in down_wait with phase==1 the slot equal to edit_digit SHALL keep an=4'b1111; in up_run/down_run with phase==1 dp SHALL be 1 in slot 2; any change of current_state or edit_digit (vs. previous cycle) SHALL clear counter and phase to 0 on the next edge.
REQ-026 When CLK_SCAN_BLINK_EN is undefined: no blink counter or phase logic exists, no slot is blanked beyond REQ-016, dp follows REQ-021 unconditionally.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-027 Reset release, inputs min2=1,min1=2,sec2=3,sec1=4 -> first frame shows 0 on all slots; from second frame slot0 an=1110 seg=7'b0011001, slot3 an=0111 seg=7'b1111001.
REQ-028 Change inputs to 9,9,5,9 while dsel==1 -> slots 1..3 of current frame keep old values; new values appear from next frame slot 0.
REQ-029 min_cnt1=4'hC -> slot 2 an=1011, seg=7'b1111111, dp=0.
REQ-030 BLINK_EN, current_state=10, edit_digit=1 -> slot 1 an=1101 during cycles 0-15 after entry, an=1111 during cycles 16-31, repeating.
REQ-031 BLINK_EN, edit_digit 1->2 while phase==1 -> phase cleared next edge; slot 2 lit on its next occurrence.
REQ-032 reset pulsed one cycle while dsel==2 -> next edge an=1111, seg=7'b1111111, dp=1, dsel=0; lit slot 0 follows after one cycle.
